// File: rtl/imply_stack.sv
// rtl/imply_stack.sv - LIFO of implied variable assignments fed by the conflict detector.
// Optional high-water-mark output enabled by defining IMPLY_STACK_HWM_EN.
`ifndef MAX_VARS
`define MAX_VARS 16
`endif
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 4
`endif

module imply_stack #(
  parameter int DEPTH    = `MAX_VARS,
  parameter int VAR_BITS = `MAX_VARS_BITS,
  parameter int CNT_BITS = $clog2(DEPTH + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                push_en,
  input  logic [VAR_BITS-1:0] var_idx_in,
  input  logic                val_in,
  input  logic                pop_en,
  input  logic                flush,
  output logic [VAR_BITS-1:0] top_var,
  output logic                top_val,
  output logic                top_valid,
  output logic                empty,
  output logic                full,
  output logic [CNT_BITS-1:0] count,
`ifdef IMPLY_STACK_HWM_EN
  output logic [CNT_BITS-1:0] high_water,
`endif
  output logic                overflow
);

  localparam int ADDR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [VAR_BITS-1:0]  mem_var [DEPTH];
  logic                 mem_val [DEPTH];

  logic [CNT_BITS-1:0]  count_nxt;
  logic                 overflow_nxt;
  logic                 wr_en;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [CNT_BITS-1:0]  cnt_m1;
  logic [ADDR_BITS-1:0] top_addr;
  logic [ADDR_BITS-1:0] push_addr;

  assign empty     = (count == '0);
  assign full      = (count == CNT_BITS'(DEPTH));
  assign top_valid = !empty;
  assign cnt_m1    = count - CNT_BITS'(1);
  assign top_addr  = cnt_m1[ADDR_BITS-1:0];
  assign push_addr = count[ADDR_BITS-1:0];

  always_comb begin
    count_nxt    = count;
    overflow_nxt = overflow;
    wr_en        = 1'b0;
    wr_addr      = push_addr;
    if (flush) begin
      count_nxt    = '0;
      overflow_nxt = 1'b0;
    end else begin
      case ({push_en, pop_en})
        2'b10: begin
          if (!full) begin
            wr_en     = 1'b1;
            count_nxt = count + CNT_BITS'(1);
          end else begin
            overflow_nxt = 1'b1;
          end
        end
        2'b01: begin
          if (!empty) count_nxt = cnt_m1;
        end
        2'b11: begin
          // Pop+push swaps the top in place, so it never overflows even when full.
          wr_en = 1'b1;
          if (!empty) begin
            wr_addr = top_addr;
          end else begin
            count_nxt = CNT_BITS'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      count    <= count_nxt;
      overflow <= overflow_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset && wr_en) begin
      mem_var[wr_addr] <= var_idx_in;
      mem_val[wr_addr] <= val_in;
    end
  end

  assign top_var = empty ? '0   : mem_var[top_addr];
  assign top_val = empty ? 1'b0 : mem_val[top_addr];

`ifdef IMPLY_STACK_HWM_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      high_water <= '0;
    end else if (count_nxt > high_water) begin
      high_water <= count_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_imply_stack.sv
// tb/tb_imply_stack.sv - directed self-checking bench for imply_stack (DEPTH=4).
module tb_imply_stack;

  localparam int DEPTH    = 4;
  localparam int VAR_BITS = 4;
  localparam int CNT_BITS = 3;

  logic                clock = 1'b0;
  logic                reset;
  logic                push_en;
  logic [VAR_BITS-1:0] var_idx_in;
  logic                val_in;
  logic                pop_en;
  logic                flush;
  logic [VAR_BITS-1:0] top_var;
  logic                top_val;
  logic                top_valid;
  logic                empty;
  logic                full;
  logic [CNT_BITS-1:0] count;
  logic                overflow;
`ifdef IMPLY_STACK_HWM_EN
  logic [CNT_BITS-1:0] high_water;
`endif

  int total = 0;
  int bad   = 0;

  imply_stack #(.DEPTH(DEPTH), .VAR_BITS(VAR_BITS), .CNT_BITS(CNT_BITS)) dut (
    .clock      (clock),
    .reset      (reset),
    .push_en    (push_en),
    .var_idx_in (var_idx_in),
    .val_in     (val_in),
    .pop_en     (pop_en),
    .flush      (flush),
    .top_var    (top_var),
    .top_val    (top_val),
    .top_valid  (top_valid),
    .empty      (empty),
    .full       (full),
    .count      (count),
`ifdef IMPLY_STACK_HWM_EN
    .high_water (high_water),
`endif
    .overflow   (overflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, then sample 1ns after the edge.
  task automatic op(input logic rst_n, input logic psh, input logic pop, input logic fl,
                    input int v, input logic b);
    reset      = rst_n;
    push_en    = psh;
    pop_en     = pop;
    flush      = fl;
    var_idx_in = VAR_BITS'(v);
    val_in     = b;
    @(posedge clock);
    #1;
    reset   = 1'b1;
    push_en = 1'b0;
    pop_en  = 1'b0;
    flush   = 1'b0;
  endtask

  task automatic push(input int v, input logic b);
    op(1'b1, 1'b1, 1'b0, 1'b0, v, b);
  endtask

  task automatic pop();
    op(1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
  endtask

  task automatic state(input string tag, input int c, input int tv, input int tb, input int ov);
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".top_var"}, 32'(top_var), 32'(tv));
    chk({tag, ".top_val"}, 32'(top_val), 32'(tb));
    chk({tag, ".top_valid"}, 32'(top_valid), (c != 0) ? 32'd1 : 32'd0);
    chk({tag, ".empty"}, 32'(empty), (c == 0) ? 32'd1 : 32'd0);
    chk({tag, ".full"}, 32'(full), (c == DEPTH) ? 32'd1 : 32'd0);
    chk({tag, ".overflow"}, 32'(overflow), 32'(ov));
  endtask

  initial begin
    op(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    state("reset", 0, 0, 0, 0);

    push(5, 1'b1);  state("push1", 1, 5, 1, 0);
    push(9, 1'b0);  state("push2", 2, 9, 0, 0);
    push(3, 1'b1);  state("push3", 3, 3, 1, 0);
    pop();          state("pop1", 2, 9, 0, 0);
    pop();          state("pop2", 1, 5, 1, 0);
    pop();          state("pop3", 0, 0, 0, 0);

    for (int i = 0; i < 3; i++) begin
      pop();        state("pop_empty", 0, 0, 0, 0);
    end

    push(1, 1'b0);
    push(2, 1'b1);
    push(4, 1'b0);
    push(6, 1'b1);  state("fill", 4, 6, 1, 0);
    push(8, 1'b1);  state("ovf_push", 4, 6, 1, 1);
    op(1'b1, 1'b1, 1'b1, 1'b0, 10, 1'b0);
    state("full_replace", 4, 10, 0, 1);
    pop();          state("after_replace", 3, 4, 0, 1);

    op(1'b1, 1'b1, 1'b0, 1'b1, 12, 1'b1);
    state("flush_push", 0, 0, 0, 0);
    push(13, 1'b0); state("post_flush", 1, 13, 0, 0);
    push(14, 1'b1); state("two", 2, 14, 1, 0);
    op(1'b1, 1'b1, 1'b1, 1'b0, 7, 1'b1);
    state("replace2", 2, 7, 1, 0);
    pop();          state("under_replace", 1, 13, 0, 0);
    pop();          state("drain", 0, 0, 0, 0);
    op(1'b1, 1'b1, 1'b1, 1'b0, 7, 1'b1);
    state("pushpop_empty", 1, 7, 1, 0);

    push(3, 1'b0);  state("pre_reset", 2, 3, 0, 0);
    op(1'b0, 1'b1, 1'b0, 1'b0, 11, 1'b1);
    state("mid_reset", 0, 0, 0, 0);

`ifdef IMPLY_STACK_HWM_EN
    chk("hwm_reset", 32'(high_water), 32'd0);
    for (int i = 0; i < 4; i++) push(i + 1, 1'b1);
    for (int i = 0; i < 2; i++) pop();
    op(1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    push(9, 1'b0);
    push(10, 1'b1);
    chk("hwm_peak", 32'(high_water), 32'd4);
    state("hwm_state", 2, 10, 1, 0);
    op(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    chk("hwm_cleared", 32'(high_water), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
